// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between a request/response handshake and a byte-addressed
// memory port with combinational read and clock-edge write.
// Aligned accesses take one memory cycle. Misaligned HALF/WORD accesses are split
// into byte accesses, unless LSU_ALIGN_TRAP_EN is defined, in which case they fault.
// Ports:
//   clock, reset                  clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_addr, req_wdata           byte address, right-aligned store data
//   req_params                    read_unsigned, access_size, op
//   resp_valid/resp_ready         response handshake, payload held while stalled
//   resp_rdata, resp_fault        extended load data (0 for stores), fault flag
//   mem_address, mem_data_in,     memory request (op READ and zeros when not accessing)
//   mem_params, mem_data_out      and combinational read data
// Config macro: LSU_ALIGN_TRAP_EN (misaligned requests fault instead of being split).

package mem_lsu_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } access_size_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        logic         read_unsigned;
        access_size_t access_size;
        mem_op_t      op;
    } mem_params_t;
endpackage

module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  mem_params_t     req_params,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data_in,
    output mem_params_t     mem_params,
    input  logic [XLEN-1:0] mem_data_out
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    mem_params_t     params_q, params_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic            split_q, split_d;

    logic            misaligned_c;
    logic            fault_req_c;
    logic            done_c;
    logic [1:0]      last_cnt_c;
    logic [XLEN-1:0] assembled_c;

    // Zero/sign extension of the assembled load value.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input mem_params_t p);
        logic [XLEN-1:0] r;
        r = v;
        if (p.access_size == SIZE_BYTE) begin
            r = p.read_unsigned ? XLEN'(v[7:0]) : {{(XLEN-8){v[7]}}, v[7:0]};
        end else if (p.access_size == SIZE_HALF) begin
            r = p.read_unsigned ? XLEN'(v[15:0]) : {{(XLEN-16){v[15]}}, v[15:0]};
        end
        return r;
    endfunction

    // Alignment check of the incoming request; BYTE is always aligned.
    assign misaligned_c = ((req_params.access_size == SIZE_HALF) && req_addr[0]) ||
                          ((req_params.access_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_ALIGN_TRAP_EN
    assign fault_req_c = (req_params.access_size == SIZE_RSVD) || misaligned_c;
`else
    assign fault_req_c = (req_params.access_size == SIZE_RSVD);
`endif

    // Index of the final byte in a split access: 1 for HALF, 3 for WORD.
    assign last_cnt_c = (params_q.access_size == SIZE_HALF) ? 2'd1 : 2'd3;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    // Next-state, memory-port drive and load assembly.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        params_d    = params_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        split_d     = split_q;
        done_c      = 1'b0;
        assembled_c = '0;
        mem_address = '0;
        mem_data_in = '0;
        mem_params  = '{read_unsigned: 1'b0, access_size: SIZE_BYTE, op: OP_READ};

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    params_d = req_params;
                    cnt_d    = 2'd0;
                    buf_d    = '0;
                    rdata_d  = '0;
                    fault_d  = fault_req_c;
                    split_d  = misaligned_c;
                    state_d  = fault_req_c ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (split_q) begin
                    mem_address = addr_q + XLEN'(cnt_q);
                    mem_data_in = XLEN'(wdata_q[{cnt_q, 3'b000} +: 8]);
                    mem_params  = '{read_unsigned: 1'b1, access_size: SIZE_BYTE, op: params_q.op};
                    assembled_c = buf_q;
                    assembled_c[{cnt_q, 3'b000} +: 8] = mem_data_out[7:0];
                    buf_d       = assembled_c;
                    cnt_d       = cnt_q + 2'd1;
                    done_c      = (cnt_q == last_cnt_c);
                end else begin
                    mem_address = addr_q;
                    mem_data_in = wdata_q;
                    mem_params  = '{read_unsigned: 1'b1, access_size: params_q.access_size,
                                    op: params_q.op};
                    assembled_c = mem_data_out;
                    buf_d       = assembled_c;
                    done_c      = 1'b1;
                end
                if (done_c) begin
                    state_d = ST_RESP;
                    rdata_d = (params_q.op == OP_WRITE) ? '0 : extend(assembled_c, params_q);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // No memory activity on the edge that applies reset, so an aborted store stops at once.
        if (!reset) begin
            mem_address = '0;
            mem_data_in = '0;
            mem_params  = '{read_unsigned: 1'b0, access_size: SIZE_BYTE, op: OP_READ};
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            params_q <= '{read_unsigned: 1'b0, access_size: SIZE_BYTE, op: OP_READ};
            cnt_q    <= 2'd0;
            fault_q  <= 1'b0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            params_q <= params_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            split_q  <= split_d;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed requests with hand-computed expectations pushed
// into a scoreboard; a negedge monitor pops and checks each response.
// A byte memory model logs every access and byte write for later comparison.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

`ifdef LSU_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    mem_params_t req_params;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    mem_params_t mem_params;
    logic [31:0] mem_data_out;

    mem_lsu dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_params   (req_params),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_params   (mem_params),
        .mem_data_out (mem_data_out)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [39:0] wr_log[$];
    logic [31:0] acc_log[$];
    logic [39:0] exp_w[$];
    logic [31:0] exp_a[$];
    logic [7:0]  mem [0:1023];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        in_resp = 1'b0;
    logic [31:0] held_rdata;
    logic        held_fault;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: combinational read, zero-extended per size.
    logic [9:0]  rd_a;
    logic [31:0] rd_raw;
    always_comb begin
        rd_a   = mem_address[9:0];
        rd_raw = {mem[rd_a + 10'd3], mem[rd_a + 10'd2], mem[rd_a + 10'd1], mem[rd_a]};
        mem_data_out = rd_raw;
        if (mem_params.access_size == SIZE_BYTE) mem_data_out = {24'h0, rd_raw[7:0]};
        else if (mem_params.access_size == SIZE_HALF) mem_data_out = {16'h0, rd_raw[15:0]};
    end

    // Memory writes, access log (DUT sets read_unsigned only while accessing) and cycle count.
    always @(posedge clock) begin
        int nb;
        cyc <= cyc + 1;
        if (mem_params.read_unsigned) acc_log.push_back(mem_address);
        if (mem_params.op == OP_WRITE) begin
            nb = (mem_params.access_size == SIZE_BYTE) ? 1 :
                 (mem_params.access_size == SIZE_HALF) ? 2 : 4;
            for (int k = 0; k < nb; k++) begin
                mem[10'(mem_address + 32'(k))] = mem_data_in[8*k +: 8];
                wr_log.push_back({mem_address + 32'(k), mem_data_in[8*k +: 8]});
            end
        end
    end

    // Response monitor.
    always @(negedge clock) begin
        exp_t cur;
        if (reset && resp_valid) begin
            if (!in_resp) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h fault %0b, none expected",
                             resp_rdata, resp_fault);
                end else begin
                    cur = sb[0];
                    chk("resp_rdata", resp_rdata, cur.rdata);
                    chk("resp_fault", resp_fault, cur.fault);
                    chk("latency", cyc - cur.acc + 1, cur.lat);
                end
                held_rdata = resp_rdata;
                held_fault = resp_fault;
                in_resp    = 1'b1;
            end else begin
                chk("hold_rdata", resp_rdata, held_rdata);
                chk("hold_fault", resp_fault, held_fault);
            end
            chk("req_ready_in_resp", req_ready, 0);
            if (resp_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                in_resp = 1'b0;
            end
        end
    end

    function automatic mem_params_t mk(input bit ru, input access_size_t s, input mem_op_t o);
        mem_params_t p;
        p.read_unsigned = ru;
        p.access_size   = s;
        p.op            = o;
        return p;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        acc_log.delete();
        exp_w.delete();
        exp_a.delete();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input mem_params_t p,
                         input bit want, input logic [31:0] er, input logic ef, input int el);
        int n = 0;
        exp_t e;
        while (!req_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_wdata  = wd;
        req_params = p;
        @(posedge clock);
        #1;
        if (want) begin
            e.rdata = er;
            e.fault = ef;
            e.lat   = el;
            e.acc   = cyc;
            sb.push_back(e);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic chk_logs(input string name);
        chk({name, "_wr_count"}, wr_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
            chk({name, "_wr"}, wr_log[i], exp_w[i]);
        chk({name, "_acc_count"}, acc_log.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < acc_log.size(); i++)
            chk({name, "_acc"}, acc_log[i], exp_a[i]);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_params = mk(1'b0, SIZE_BYTE, OP_READ);
        resp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'hEF; mem[10'h101] = 8'hBE; mem[10'h102] = 8'hAD; mem[10'h103] = 8'hDE;
        mem[10'h201] = 8'h80; mem[10'h202] = 8'hFF;
        mem[10'h300] = 8'h9C;
        mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_op", mem_params.op, OP_READ);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_din", mem_data_in, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Aligned LW.
        clear_logs();
        issue(32'h100, 32'h0, mk(1'b0, SIZE_WORD, OP_READ), 1'b1, 32'hDEADBEEF, 1'b0, 2);
        drain();
        exp_a.push_back(32'h100);
        chk_logs("lw_aligned");

        // Misaligned SW.
        clear_logs();
        if (TRAP) begin
            issue(32'h101, 32'h11223344, mk(1'b0, SIZE_WORD, OP_WRITE), 1'b1, 32'h0, 1'b1, 1);
        end else begin
            issue(32'h101, 32'h11223344, mk(1'b0, SIZE_WORD, OP_WRITE), 1'b1, 32'h0, 1'b0, 5);
            exp_w.push_back({32'h101, 8'h44}); exp_w.push_back({32'h102, 8'h33});
            exp_w.push_back({32'h103, 8'h22}); exp_w.push_back({32'h104, 8'h11});
            exp_a.push_back(32'h101); exp_a.push_back(32'h102);
            exp_a.push_back(32'h103); exp_a.push_back(32'h104);
        end
        drain();
        chk_logs("sw_misaligned");

        // Read back the word touched by the split store.
        clear_logs();
        issue(32'h100, 32'h0, mk(1'b1, SIZE_WORD, OP_READ), 1'b1,
              TRAP ? 32'hDEADBEEF : 32'h223344EF, 1'b0, 2);
        drain();

        // Misaligned LH / LHU.
        clear_logs();
        if (TRAP) issue(32'h201, 32'h0, mk(1'b0, SIZE_HALF, OP_READ), 1'b1, 32'h0, 1'b1, 1);
        else begin
            issue(32'h201, 32'h0, mk(1'b0, SIZE_HALF, OP_READ), 1'b1, 32'hFFFFFF80, 1'b0, 3);
            exp_a.push_back(32'h201); exp_a.push_back(32'h202);
        end
        drain();
        chk_logs("lh_misaligned");
        clear_logs();
        issue(32'h201, 32'h0, mk(1'b1, SIZE_HALF, OP_READ), 1'b1,
              TRAP ? 32'h0 : 32'h0000FF80, TRAP, TRAP ? 1 : 3);
        drain();

        // LB signed / unsigned.
        clear_logs();
        issue(32'h300, 32'h0, mk(1'b0, SIZE_BYTE, OP_READ), 1'b1, 32'hFFFFFF9C, 1'b0, 2);
        drain();
        issue(32'h300, 32'h0, mk(1'b1, SIZE_BYTE, OP_READ), 1'b1, 32'h0000009C, 1'b0, 2);
        drain();

        // Reserved size store faults with no memory access.
        clear_logs();
        issue(32'h310, 32'h12345678, mk(1'b0, SIZE_RSVD, OP_WRITE), 1'b1, 32'h0, 1'b1, 1);
        drain();
        chk_logs("rsvd");

        // Aligned SB.
        clear_logs();
        issue(32'h320, 32'h123456A5, mk(1'b0, SIZE_BYTE, OP_WRITE), 1'b1, 32'h0, 1'b0, 2);
        drain();
        exp_w.push_back({32'h320, 8'hA5});
        exp_a.push_back(32'h320);
        chk_logs("sb_aligned");

        // Misaligned LW wrapping past the top of the address space.
        clear_logs();
        if (TRAP) issue(32'hFFFFFFFE, 32'h0, mk(1'b0, SIZE_WORD, OP_READ), 1'b1, 32'h0, 1'b1, 1);
        else begin
            issue(32'hFFFFFFFE, 32'h0, mk(1'b0, SIZE_WORD, OP_READ), 1'b1, 32'h44332211, 1'b0, 5);
            exp_a.push_back(32'hFFFFFFFE); exp_a.push_back(32'hFFFFFFFF);
            exp_a.push_back(32'h00000000); exp_a.push_back(32'h00000001);
        end
        drain();
        chk_logs("lw_wrap");

        // Response held while resp_ready is low.
        clear_logs();
        resp_ready = 1'b0;
        issue(32'h300, 32'h0, mk(1'b0, SIZE_BYTE, OP_READ), 1'b1, 32'hFFFFFF9C, 1'b0, 2);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("hold_wait_valid", resp_valid, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("hold_still_valid", resp_valid, 1);
        chk("hold_req_ready", req_ready, 0);
        resp_ready = 1'b1;
        drain();

        // Reset during a split store: only bytes before the reset edge land.
        clear_logs();
        issue(32'h181, 32'hAABBCCDD, mk(1'b0, SIZE_WORD, OP_WRITE), TRAP, 32'h0, 1'b1, 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_resp_valid", resp_valid, 0);
        drain();
        if (!TRAP) begin
            exp_w.push_back({32'h181, 8'hDD}); exp_w.push_back({32'h182, 8'hCC});
            exp_a.push_back(32'h181); exp_a.push_back(32'h182);
        end
        chk_logs("abort");

        // Normal operation after the abort.
        clear_logs();
        issue(32'h201, 32'h0, mk(1'b1, SIZE_BYTE, OP_READ), 1'b1, 32'h00000080, 1'b0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
